rx_align_ctrl: RTL and testbench
================================

Name: rx_align_ctrl

Overview:
Comma-alignment and sync controller for the 1G Ethernet PCS receive path.
- Watches the 20-bit transceiver word for K28.5 commas.
- Sequences the transceiver rxslide pulses until a comma position is stable, then declares sync.
- Emits a 20-bit code-group pair with the comma always in the upper half.
- Sits between the GT RX parallel interface and the 8b/10b decoder.

Parameters:
SLIDE_HIGH, 2, cycles rxslide is held high per slide request
SETTLE_CYC, 32, cycles data is ignored after a slide (GT settling)
HUNT_CYC, 36, cycles spent searching for a comma before issuing another slide
WINDOW, 16, cycles per comma-check window in CHECK and LOCKED
LOCK_COMMAS, 3, consecutive good windows required to enter LOCKED
LOSS_MISSES, 4, consecutive bad windows in LOCKED that drop sync
NUM_SLIDES, 20, slide positions per full bit rotation

Ports:
clk  in  1  core clock, one 20-bit word per cycle
rst  in  1  synchronous, active-high reset
rx_data  in  20  raw GT parallel word; [19:10] is the first code group
rxslide  out  1  slide request to the GT
sync_ok  out  1  high while in LOCKED
sync_loss  out  1  1-cycle pulse on LOCKED->HUNT
slide_wrap  out  1  1-cycle pulse when slide_cnt wraps NUM_SLIDES-1 -> 0
slide_cnt  out  5  slides issued since last wrap
comma_pos  out  1  0 = comma in upper half, 1 = comma in lower half
aligned_data  out  20  re-paired code groups, comma-carrying group in [19:10]
aligned_valid  out  1  aligned_data valid

Behaviour:
Reset:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- On reset, all outputs are 0, state = HUNT, and all counters are 0.

Comma detect (combinational):
- comma_hi = rx_data[19:10] is 10'b0011111010 or 10'b1100000101.
- comma_lo is the same test on rx_data[9:0].

States (one window/phase counter, reset on every transition):
- HUNT: runs for HUNT_CYC cycles.
  - comma_hi -> latch comma_pos=0, go to CHECK.
  - Else comma_lo -> latch comma_pos=1, go to CHECK.
  - If both are set, upper wins (comma_pos=0).
  - Counter reaches HUNT_CYC-1 with no comma -> SLIDE.
- SLIDE:
  - rxslide = 1 for exactly SLIDE_HIGH cycles, then go to SETTLE.
  - slide_cnt increments on SLIDE entry, modulo NUM_SLIDES.
  - The 19->0 wrap pulses slide_wrap in the same cycle as the increment.
- SETTLE: rxslide = 0, rx_data ignored for SETTLE_CYC cycles, then go to HUNT.
- CHECK (windows of WINDOW cycles):
  - A window is good if at least one cycle shows a comma at the latched half.
  - Comma at the other half only, with none at the latched half during the window -> HUNT at window end.
  - Window with no comma at all -> SLIDE.
  - A good window increments good_cnt; good_cnt reaching LOCK_COMMAS -> LOCKED.
  - good_cnt clears on leaving CHECK.
- LOCKED:
  - sync_ok = 1 from the first LOCKED cycle.
  - A window with a comma at the latched half clears miss_cnt; otherwise miss_cnt increments.
  - A comma at the wrong half counts as a miss.
  - miss_cnt reaching LOSS_MISSES -> HUNT; sync_ok drops the same cycle and sync_loss pulses 1 cycle.
  - slide_cnt is held in LOCKED.

Alignment datapath:
- prev_lo register captures rx_data[9:0] every cycle.
- comma_pos=0: aligned_data <= rx_data (registered, latency 1).
- comma_pos=1: aligned_data <= {prev_lo, rx_data[19:10]} (latency 1 from the second word).
- aligned_valid <= (state == LOCKED), registered alongside the data.
- aligned_valid drops 1 cycle after sync_ok drops.
- rxslide is never asserted outside SLIDE.

Decomposition:
- Shared package pcs_pkg holds:
  - K28_5_RDN = 10'b0011111010 and K28_5_RDP = 10'b1100000101;
  - the state enum {HUNT, SLIDE, SETTLE, CHECK, LOCKED}.
- One sub-module is natural: comma_det (10-bit in, 1-bit out, combinational), instantiated twice.
- The FSM and the datapath stay in rx_align_ctrl.

Test Plan:
- Random non-comma data, 200 cycles -> first rxslide rises at cycle 36, lasts 2 cycles, next rise at cycle 36+2+32+36=106, slide_cnt=1 then 2, sync_ok=0.
- 0x0FA in [19:10] every 2nd cycle from reset -> comma_pos=0, sync_ok=1 after 3 windows (~48 cycles), aligned_data == rx_data delayed 1 cycle, no rxslide.
- 0x305 in [9:0] every cycle, next word upper = 0x2AA -> comma_pos=1, after lock aligned_data = {0x305, 0x2AA}.
- Locked, then remove commas -> sync_loss pulses once after 4 full windows (64 cycles); sync_ok falls that cycle; HUNT restarts.
- 20 slides with no comma -> slide_wrap pulses once on slide 20, slide_cnt returns to 0.
- rst asserted mid-SLIDE (rxslide=1) -> next cycle rxslide=0, slide_cnt=0, state HUNT.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared definitions for the 1G Ethernet PCS receive path: K28.5 comma
// encodings and the comma-alignment controller state type.
package pcs_pkg;

    // K28.5 in both running disparities, bit order as delivered by the GT.
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        SLIDE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        LOCKED = 3'd4
    } align_state_e;

endpackage

// File: rtl/rx_align_ctrl_comma_det.sv
// Combinational K28.5 detector for one 10-bit code group (either disparity).
module comma_det
    import pcs_pkg::*;
(
    input  logic [9:0] code,
    input  logic       en,
    output logic       comma
);

    // Match against both disparities of K28.5.
    always_comb begin
        comma = 1'b0;
        if (en) begin
            comma = (code == K28_5_RDN) || (code == K28_5_RDP);
        end else begin
            comma = 1'b0;
        end
    end

endmodule

// File: rtl/rx_align_ctrl.sv
// Comma-alignment and sync controller between the GT RX parallel interface
// and the 8b/10b decoder. Slides the GT until a K28.5 lands at a stable half
// of the 20-bit word, then re-pairs code groups so the comma sits in [19:10].
module rx_align_ctrl
    import pcs_pkg::*;
#(
    parameter int unsigned SLIDE_HIGH  = 2,
    parameter int unsigned SETTLE_CYC  = 32,
    parameter int unsigned HUNT_CYC    = 36,
    parameter int unsigned WINDOW      = 16,
    parameter int unsigned LOCK_COMMAS = 3,
    parameter int unsigned LOSS_MISSES = 4,
    parameter int unsigned NUM_SLIDES  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] rx_data,
    output logic        rxslide,
    output logic        sync_ok,
    output logic        sync_loss,
    output logic        slide_wrap,
    output logic [4:0]  slide_cnt,
    output logic        comma_pos,
    output logic [19:0] aligned_data,
    output logic        aligned_valid
);

    localparam logic [5:0] HUNT_LAST   = 6'(HUNT_CYC - 1);
    localparam logic [5:0] SLIDE_LAST  = 6'(SLIDE_HIGH - 1);
    localparam logic [5:0] SETTLE_LAST = 6'(SETTLE_CYC - 1);
    localparam logic [5:0] WIN_LAST    = 6'(WINDOW - 1);
    localparam logic [2:0] GOOD_LOCK   = 3'(LOCK_COMMAS);
    localparam logic [2:0] MISS_LOSS   = 3'(LOSS_MISSES);
    localparam logic [4:0] WRAP_LAST   = 5'(NUM_SLIDES - 1);

    align_state_e state_r;
    logic [5:0]   cnt_r;
    logic [2:0]   good_cnt_r;
    logic [2:0]   miss_cnt_r;
    logic         seen_lat_r;
    logic         seen_oth_r;
    logic [9:0]   prev_lo_r;

    logic         comma_hi_s;
    logic         comma_lo_s;
    logic         det_en_s;
    logic         lat_now_s;
    logic         oth_now_s;
    logic         win_good_s;
    logic         win_oth_s;
    logic         win_end_s;
    logic [4:0]   slide_next_s;
    logic         slide_wraps_s;

    // Data is meaningless while the GT settles after a slide.
    assign det_en_s = (state_r != SETTLE);

    comma_det u_det_hi (.code(rx_data[19:10]), .en(det_en_s), .comma(comma_hi_s));
    comma_det u_det_lo (.code(rx_data[9:0]),   .en(det_en_s), .comma(comma_lo_s));

    // Window evaluation relative to the latched comma half, including this cycle.
    always_comb begin
        lat_now_s     = 1'b0;
        oth_now_s     = 1'b0;
        if (comma_pos) begin
            lat_now_s = comma_lo_s;
            oth_now_s = comma_hi_s;
        end else begin
            lat_now_s = comma_hi_s;
            oth_now_s = comma_lo_s;
        end
        win_good_s    = seen_lat_r | lat_now_s;
        win_oth_s     = seen_oth_r | oth_now_s;
        win_end_s     = (cnt_r == WIN_LAST);
        slide_wraps_s = (slide_cnt == WRAP_LAST);
        if (slide_wraps_s) begin
            slide_next_s = 5'd0;
        end else begin
            slide_next_s = slide_cnt + 5'd1;
        end
    end

    // Alignment FSM with registered control outputs and window bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= HUNT;
            cnt_r      <= 6'd0;
            good_cnt_r <= 3'd0;
            miss_cnt_r <= 3'd0;
            seen_lat_r <= 1'b0;
            seen_oth_r <= 1'b0;
            rxslide    <= 1'b0;
            sync_ok    <= 1'b0;
            sync_loss  <= 1'b0;
            slide_wrap <= 1'b0;
            slide_cnt  <= 5'd0;
            comma_pos  <= 1'b0;
        end else begin
            sync_loss  <= 1'b0;
            slide_wrap <= 1'b0;
            case (state_r)
                HUNT: begin
                    if (comma_hi_s) begin
                        comma_pos <= 1'b0;
                        state_r   <= CHECK;
                        cnt_r     <= 6'd0;
                    end else if (comma_lo_s) begin
                        comma_pos <= 1'b1;
                        state_r   <= CHECK;
                        cnt_r     <= 6'd0;
                    end else if (cnt_r == HUNT_LAST) begin
                        state_r    <= SLIDE;
                        cnt_r      <= 6'd0;
                        rxslide    <= 1'b1;
                        slide_cnt  <= slide_next_s;
                        slide_wrap <= slide_wraps_s;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                SLIDE: begin
                    if (cnt_r == SLIDE_LAST) begin
                        state_r <= SETTLE;
                        cnt_r   <= 6'd0;
                        rxslide <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                SETTLE: begin
                    rxslide <= 1'b0;
                    if (cnt_r == SETTLE_LAST) begin
                        state_r <= HUNT;
                        cnt_r   <= 6'd0;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                CHECK: begin
                    if (win_end_s) begin
                        cnt_r      <= 6'd0;
                        seen_lat_r <= 1'b0;
                        seen_oth_r <= 1'b0;
                        if (win_good_s) begin
                            if (good_cnt_r + 3'd1 == GOOD_LOCK) begin
                                state_r    <= LOCKED;
                                good_cnt_r <= 3'd0;
                                miss_cnt_r <= 3'd0;
                                sync_ok    <= 1'b1;
                            end else begin
                                good_cnt_r <= good_cnt_r + 3'd1;
                            end
                        end else if (win_oth_s) begin
                            state_r    <= HUNT;
                            good_cnt_r <= 3'd0;
                        end else begin
                            state_r    <= SLIDE;
                            good_cnt_r <= 3'd0;
                            rxslide    <= 1'b1;
                            slide_cnt  <= slide_next_s;
                            slide_wrap <= slide_wraps_s;
                        end
                    end else begin
                        cnt_r      <= cnt_r + 6'd1;
                        seen_lat_r <= win_good_s;
                        seen_oth_r <= win_oth_s;
                    end
                end
                LOCKED: begin
                    if (win_end_s) begin
                        cnt_r      <= 6'd0;
                        seen_lat_r <= 1'b0;
                        seen_oth_r <= 1'b0;
                        if (win_good_s) begin
                            miss_cnt_r <= 3'd0;
                        end else if (miss_cnt_r + 3'd1 == MISS_LOSS) begin
                            state_r    <= HUNT;
                            miss_cnt_r <= 3'd0;
                            sync_ok    <= 1'b0;
                            sync_loss  <= 1'b1;
                        end else begin
                            miss_cnt_r <= miss_cnt_r + 3'd1;
                        end
                    end else begin
                        cnt_r      <= cnt_r + 6'd1;
                        seen_lat_r <= win_good_s;
                        seen_oth_r <= win_oth_s;
                    end
                end
                default: begin
                    state_r    <= HUNT;
                    cnt_r      <= 6'd0;
                    good_cnt_r <= 3'd0;
                    miss_cnt_r <= 3'd0;
                    seen_lat_r <= 1'b0;
                    seen_oth_r <= 1'b0;
                    rxslide    <= 1'b0;
                    sync_ok    <= 1'b0;
                end
            endcase
        end
    end

    // Re-pair code groups so the comma-carrying group always lands in [19:10].
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_lo_r     <= 10'd0;
            aligned_data  <= 20'd0;
            aligned_valid <= 1'b0;
        end else begin
            prev_lo_r <= rx_data[9:0];
            if (comma_pos) begin
                aligned_data <= {prev_lo_r, rx_data[19:10]};
            end else begin
                aligned_data <= rx_data;
            end
            aligned_valid <= (state_r == LOCKED);
        end
    end

endmodule

// File: tb/tb_rx_align_ctrl.sv
// Directed bench for rx_align_ctrl. Cycle c is the state visible after the
// c-th active edge following reset release; inputs for cycle c are driven at
// the same falling edge where cycle c's outputs are checked.
module tb_rx_align_ctrl;
    import pcs_pkg::*;

    localparam int M_RAND  = 0;
    localparam int M_UPPER = 1;
    localparam int M_LOWER = 2;
    localparam int M_BOTH  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] rx_data = 20'd0;
    logic        rxslide, sync_ok, sync_loss, slide_wrap, comma_pos, aligned_valid;
    logic [4:0]  slide_cnt;
    logic [19:0] aligned_data;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cnum     = 0;
    int          mode     = M_RAND;
    logic [19:0] last_word = 20'd0;
    int          slide_seen;
    int          wrap_seen;

    rx_align_ctrl dut (
        .clk(clk), .rst(rst), .rx_data(rx_data),
        .rxslide(rxslide), .sync_ok(sync_ok), .sync_loss(sync_loss),
        .slide_wrap(slide_wrap), .slide_cnt(slide_cnt), .comma_pos(comma_pos),
        .aligned_data(aligned_data), .aligned_valid(aligned_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cnum);
        end
    endtask

    task automatic drive();
        logic [9:0] hi;
        logic [9:0] lo;
        hi = 10'($urandom);
        lo = 10'($urandom);
        if (hi == K28_5_RDN || hi == K28_5_RDP) hi = hi ^ 10'd1;
        if (lo == K28_5_RDN || lo == K28_5_RDP) lo = lo ^ 10'd1;
        case (mode)
            M_UPPER: if (cnum % 2 == 0) hi = K28_5_RDN;
            M_LOWER: begin hi = 10'h2AA; lo = K28_5_RDP; end
            M_BOTH:  begin hi = K28_5_RDN; lo = K28_5_RDP; end
            default: ;
        endcase
        last_word = rx_data;
        rx_data   = {hi, lo};
    endtask

    task automatic cyc();
        @(negedge clk);
        cnum++;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        cnum = 0;
        drive();
    endtask

    initial begin
        // Reset state, then no commas: slide cadence and slide_cnt wrap.
        mode = M_RAND;
        do_reset();
        chk("rst_rxslide", 20'(rxslide), 20'd0);
        chk("rst_sync_ok", 20'(sync_ok), 20'd0);
        chk("rst_sync_loss", 20'(sync_loss), 20'd0);
        chk("rst_slide_wrap", 20'(slide_wrap), 20'd0);
        chk("rst_slide_cnt", 20'(slide_cnt), 20'd0);
        chk("rst_comma_pos", 20'(comma_pos), 20'd0);
        chk("rst_aligned_data", aligned_data, 20'd0);
        chk("rst_aligned_valid", 20'(aligned_valid), 20'd0);
        wrap_seen = 0;
        for (int c = 1; c <= 1366; c++) begin
            cyc();
            if (slide_wrap) wrap_seen++;
            if (c == 35)  chk("slide1_pre", 20'(rxslide), 20'd0);
            if (c == 36) begin
                chk("slide1_rise", 20'(rxslide), 20'd1);
                chk("slide1_cnt", 20'(slide_cnt), 20'd1);
            end
            if (c == 37)  chk("slide1_hold", 20'(rxslide), 20'd1);
            if (c == 38)  chk("slide1_fall", 20'(rxslide), 20'd0);
            if (c == 105) chk("slide2_pre", 20'(rxslide), 20'd0);
            if (c == 106) begin
                chk("slide2_rise", 20'(rxslide), 20'd1);
                chk("slide2_cnt", 20'(slide_cnt), 20'd2);
            end
            if (c == 200) begin
                chk("nocomma_sync_ok", 20'(sync_ok), 20'd0);
                chk("slide3_cnt", 20'(slide_cnt), 20'd3);
            end
            if (c == 1365) begin
                chk("pre_wrap_cnt", 20'(slide_cnt), 20'd19);
                chk("pre_wrap_pulse", 20'(slide_wrap), 20'd0);
            end
        end
        chk("wrap_cnt", 20'(slide_cnt), 20'd0);
        chk("wrap_pulse", 20'(slide_wrap), 20'd1);
        chk("wrap_pulses_total", 20'(wrap_seen), 20'd1);
        chk("wrap_rxslide", 20'(rxslide), 20'd1);

        // Reset while rxslide is high.
        rst = 1'b1;
        @(negedge clk);
        chk("midslide_rst_rxslide", 20'(rxslide), 20'd0);
        chk("midslide_rst_slide_cnt", 20'(slide_cnt), 20'd0);
        chk("midslide_rst_state", 20'(dut.state_r), 20'(HUNT));

        // Upper-half comma every second cycle: lock, passthrough, then loss.
        mode = M_UPPER;
        do_reset();
        slide_seen = 0;
        for (int c = 1; c <= 165; c++) begin
            if (c == 65) mode = M_RAND;
            cyc();
            if (c <= 64 && rxslide) slide_seen++;
            if (c == 1)   chk("upper_comma_pos", 20'(comma_pos), 20'd0);
            if (c == 48)  chk("upper_pre_lock", 20'(sync_ok), 20'd0);
            if (c == 49) begin
                chk("upper_lock", 20'(sync_ok), 20'd1);
                chk("upper_valid_lag", 20'(aligned_valid), 20'd0);
            end
            if (c == 50)  chk("upper_valid", 20'(aligned_valid), 20'd1);
            if (c == 60)  chk("upper_data", aligned_data, last_word);
            if (c == 61)  chk("upper_data2", aligned_data, last_word);
            if (c == 128) begin
                chk("loss_pre_sync_ok", 20'(sync_ok), 20'd1);
                chk("loss_pre_pulse", 20'(sync_loss), 20'd0);
            end
            if (c == 129) begin
                chk("loss_sync_ok", 20'(sync_ok), 20'd0);
                chk("loss_pulse", 20'(sync_loss), 20'd1);
                chk("loss_valid_lag", 20'(aligned_valid), 20'd1);
            end
            if (c == 130) begin
                chk("loss_pulse_end", 20'(sync_loss), 20'd0);
                chk("loss_valid_drop", 20'(aligned_valid), 20'd0);
            end
            if (c == 164) chk("rehunt_pre_slide", 20'(rxslide), 20'd0);
            if (c == 165) begin
                chk("rehunt_slide", 20'(rxslide), 20'd1);
                chk("rehunt_slide_cnt", 20'(slide_cnt), 20'd1);
            end
        end
        chk("upper_no_slide", 20'(slide_seen), 20'd0);

        // Lower-half comma: re-paired output, then both halves prefer upper.
        mode = M_LOWER;
        do_reset();
        for (int c = 1; c <= 130; c++) begin
            if (c == 65)  mode = M_RAND;
            if (c == 129) mode = M_BOTH;
            cyc();
            if (c == 1)   chk("lower_comma_pos", 20'(comma_pos), 20'd1);
            if (c == 49)  chk("lower_lock", 20'(sync_ok), 20'd1);
            if (c == 52) begin
                chk("lower_data", aligned_data, 20'hC16AA);
                chk("lower_valid", 20'(aligned_valid), 20'd1);
            end
            if (c == 129) begin
                chk("lower_loss", 20'(sync_loss), 20'd1);
                chk("lower_pos_held", 20'(comma_pos), 20'd1);
            end
            if (c == 130) chk("both_upper_wins", 20'(comma_pos), 20'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
